// File: rtl/mem_arbiter_multi_if.sv
// Bundles the requester-side and RAM-side signals of the multi-port memory arbiter.
// The arbiter takes the master view. A requester/RAM model takes the slave view.
interface mem_arbiter_multi_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [NUM_PORTS-1:0]        req_ren;
  logic [NUM_PORTS-1:0]        req_wen;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]           req_rdata;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS-1:0]        req_wait;

  logic                        ram_ren;
  logic                        ram_wen;
  logic [ADDR_W-1:0]           ram_addr;
  logic [DATA_W-1:0]           ram_wdata;
  logic [DATA_W-1:0]           ram_rdata;
  logic                        ram_busy;

  modport master (
    input  req_ren, req_wen, req_addr, req_wdata, ram_rdata, ram_busy,
    output req_rdata, req_ready, req_wait, ram_ren, ram_wen, ram_addr, ram_wdata
  );

  modport slave (
    output req_ren, req_wen, req_addr, req_wdata, ram_rdata, ram_busy,
    input  req_rdata, req_ready, req_wait, ram_ren, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter_multi.sv
// Arbitrates NUM_PORTS requesters onto one single-ported RAM with a busy handshake.
// Arbitration is either fixed priority or round-robin. Each access is latched and then replayed to the RAM.
module mem_arbiter_multi #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RR_MODE   = 0
) (
  input logic                 CLK,
  input logic                 RST,
  mem_arbiter_multi_if.master bus
);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t               state;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;
  logic                 ren_q;
  logic                 wen_q;
  logic [ADDR_W-1:0]    lat_addr;
  logic [DATA_W-1:0]    lat_wdata;
  logic [DATA_W-1:0]    rdata_q;
  logic [NUM_PORTS-1:0] ready_q;
  logic [NUM_PORTS-1:0] request;
  logic [ADDR_W-1:0]    addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0]    wdata_arr [NUM_PORTS];

  assign request = bus.req_ren | bus.req_wen;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addr_arr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = bus.req_wdata[g*DATA_W +: DATA_W];
  end

  // Round-robin searches upward from the port after the last winner, wrapping around.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        cand     = (int'(rr_ptr) + k) % NUM_PORTS;
        cand_idx = IDX_W'(cand);
        if (!win_found && request[cand_idx]) begin
          win_found = 1'b1;
          win_idx   = cand_idx;
        end
      end
    end else begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (request[IDX_W'(i)]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= IDX_W'(NUM_PORTS - 1);
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      ready_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_found) begin
            grant_idx <= win_idx;
            wen_q     <= bus.req_wen[win_idx];
            ren_q     <= ~bus.req_wen[win_idx];
            lat_addr  <= addr_arr[win_idx];
            lat_wdata <= wdata_arr[win_idx];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.ram_busy) begin
            if (!wen_q) begin
              rdata_q <= bus.ram_rdata;
            end
            rr_ptr  <= grant_idx;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            ready_q <= NUM_PORTS'(1) << grant_idx;
            state   <= RESP;
          end
        end
        RESP: begin
          ready_q <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The RAM sees only latched copies, so requesters may drop or change inputs mid-access.
  assign bus.ram_ren   = ren_q;
  assign bus.ram_wen   = wen_q;
  assign bus.ram_addr  = lat_addr;
  assign bus.ram_wdata = lat_wdata;
  assign bus.req_rdata = rdata_q;
  assign bus.req_ready = ready_q;
  assign bus.req_wait  = request & ~ready_q;
endmodule
